// File: rtl/tx_frame_buffer.sv
// Ping-pong transmit frame buffer: assembles fixed-length frames from a word stream
// and releases each one to the frame FSM after TX_ACK. All control state is TMR-voted.
module tx_frame_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_WORDS = 100,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  TX_ACK,
  output logic                  VALID,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  BUF_FULL,
  output logic                  OVFL,
  output logic [1:0]            RD_STATE
);

  localparam int            CW       = $clog2(FRAME_WORDS);
  localparam logic [CW-1:0] LAST     = CW'(FRAME_WORDS - 1);
  localparam logic [3:0]    GAP_LOAD = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    SEND     = 2'd2,
    GAP      = 2'd3
  } rd_state_t;

  // Three physical copies of every control register.
  logic [1:0]    state_0, state_1, state_2;
  logic          wsel_0, wsel_1, wsel_2;
  logic          rsel_0, rsel_1, rsel_2;
  logic [CW-1:0] wcnt_0, wcnt_1, wcnt_2;
  logic [CW-1:0] rcnt_0, rcnt_1, rcnt_2;
  logic [1:0]    full_0, full_1, full_2;
  logic [3:0]    gap_0, gap_1, gap_2;

  rd_state_t       state_v, state_n;
  logic            wsel_v, wsel_n, rsel_v, rsel_n;
  logic [CW-1:0]   wcnt_v, wcnt_n, rcnt_v, rcnt_n;
  logic [1:0]      full_v, full_n;
  logic [3:0]      gap_v, gap_n;
  logic            wr_ok;
  logic [DATA_WIDTH-1:0] dout_q, dout_n;

  logic [DATA_WIDTH-1:0] mem [2][FRAME_WORDS];

  // Bitwise majority: any single corrupted copy is outvoted.
  assign state_v = rd_state_t'((state_0 & state_1) | (state_0 & state_2) | (state_1 & state_2));
  assign wsel_v  = (wsel_0 & wsel_1) | (wsel_0 & wsel_2) | (wsel_1 & wsel_2);
  assign rsel_v  = (rsel_0 & rsel_1) | (rsel_0 & rsel_2) | (rsel_1 & rsel_2);
  assign wcnt_v  = (wcnt_0 & wcnt_1) | (wcnt_0 & wcnt_2) | (wcnt_1 & wcnt_2);
  assign rcnt_v  = (rcnt_0 & rcnt_1) | (rcnt_0 & rcnt_2) | (rcnt_1 & rcnt_2);
  assign full_v  = (full_0 & full_1) | (full_0 & full_2) | (full_1 & full_2);
  assign gap_v   = (gap_0 & gap_1) | (gap_0 & gap_2) | (gap_1 & gap_2);

  assign wr_ok = WR_EN && !full_v[wsel_v];

  // NOTE: every variable gets a default at the top of an always_comb so no path infers a latch.
  always_comb begin
    state_n = state_v;
    case (state_v)
      IDLE:     if (full_v[rsel_v]) state_n = WAIT_ACK;
      WAIT_ACK: if (TX_ACK) state_n = SEND;
      SEND:     if (rcnt_v == LAST) state_n = GAP;
      GAP:      if (gap_v <= 4'd1) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    wsel_n = wsel_v;
    wcnt_n = wcnt_v;
    rsel_n = rsel_v;
    rcnt_n = rcnt_v;
    gap_n  = gap_v;
    full_n = full_v;
    dout_n = dout_q;

    if (wr_ok) begin
      if (wcnt_v == LAST) begin
        wcnt_n         = '0;
        wsel_n         = ~wsel_v;
        full_n[wsel_v] = 1'b1;
      end else begin
        wcnt_n = wcnt_v + 1'b1;
      end
    end

    // Word 0 is prefetched so it sits on DOUT while waiting for the ack.
    case (state_v)
      IDLE:     if (full_v[rsel_v]) dout_n = mem[rsel_v][0];
      WAIT_ACK: begin
        dout_n = mem[rsel_v][0];
        if (TX_ACK) rcnt_n = '0;
      end
      SEND: begin
        if (rcnt_v == LAST) begin
          full_n[rsel_v] = 1'b0;
          rsel_n         = ~rsel_v;
          rcnt_n         = '0;
          gap_n          = GAP_LOAD;
        end else begin
          rcnt_n = rcnt_v + 1'b1;
          dout_n = mem[rsel_v][rcnt_v + 1'b1];
        end
      end
      GAP:      if (gap_v != 4'd0) gap_n = gap_v - 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    VALID    = (state_v == WAIT_ACK) || (state_v == SEND);
    RD_STATE = state_v;
    DOUT     = dout_q;
    BUF_FULL = full_v[0] & full_v[1];
    OVFL     = WR_EN && full_v[wsel_v];
  end

  // NOTE: sequential state uses non-blocking assignments so all copies sample the same voted values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_0 <= IDLE;  state_1 <= IDLE;  state_2 <= IDLE;
      wsel_0  <= 1'b0;  wsel_1  <= 1'b0;  wsel_2  <= 1'b0;
      rsel_0  <= 1'b0;  rsel_1  <= 1'b0;  rsel_2  <= 1'b0;
      wcnt_0  <= '0;    wcnt_1  <= '0;    wcnt_2  <= '0;
      rcnt_0  <= '0;    rcnt_1  <= '0;    rcnt_2  <= '0;
      full_0  <= '0;    full_1  <= '0;    full_2  <= '0;
      gap_0   <= '0;    gap_1   <= '0;    gap_2   <= '0;
      dout_q  <= '0;
    end else begin
      state_0 <= state_n; state_1 <= state_n; state_2 <= state_n;
      wsel_0  <= wsel_n;  wsel_1  <= wsel_n;  wsel_2  <= wsel_n;
      rsel_0  <= rsel_n;  rsel_1  <= rsel_n;  rsel_2  <= rsel_n;
      wcnt_0  <= wcnt_n;  wcnt_1  <= wcnt_n;  wcnt_2  <= wcnt_n;
      rcnt_0  <= rcnt_n;  rcnt_1  <= rcnt_n;  rcnt_2  <= rcnt_n;
      full_0  <= full_n;  full_1  <= full_n;  full_2  <= full_n;
      gap_0   <= gap_n;   gap_1   <= gap_n;   gap_2   <= gap_n;
      dout_q  <= dout_n;
    end
  end

  // NOTE: frame storage is deliberately not reset; the full flags alone decide what is readable.
  always_ff @(posedge CLK) begin
    if (!RST && wr_ok) mem[wsel_v][wcnt_v] <= WR_DATA;
  end

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Scoreboard bench for tx_frame_buffer (4-word frames, 2-cycle gap): stimulus pushes
// expected stream words, a monitor pops and compares every SEND cycle.
module tb_tx_frame_buffer;

  localparam int FW  = 4;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        tx_ack;
  logic        valid;
  logic [15:0] dout;
  logic        buf_full;
  logic        ovfl;
  logic [1:0]  rd_state;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic        model_rsel = 1'b0;

  tx_frame_buffer #(
    .DATA_WIDTH (16),
    .FRAME_WORDS(FW),
    .GAP_CYCLES (GAP)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .WR_EN   (wr_en),
    .WR_DATA (wr_data),
    .TX_ACK  (tx_ack),
    .VALID   (valid),
    .DOUT    (dout),
    .BUF_FULL(buf_full),
    .OVFL    (ovfl),
    .RD_STATE(rd_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every SEND cycle must present the next expected word.
  initial begin
    logic [15:0] exp_w;
    forever begin
      @(negedge clk);
      if (rd_state == 2'd2) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_unexpected: got DOUT=%0h with no word expected at %0t", dout, $time);
        end else begin
          exp_w = exp_q.pop_front();
          check("stream_word", dout, exp_w);
          check("stream_valid", valid, 1'b1);
        end
      end
    end
  end

  task automatic write_words(input int first, input int n, input int drop_from);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'(first + i);
      if (i < drop_from) exp_q.push_back(16'(first + i));
      @(negedge clk);
      check("wr_ovfl", ovfl, (i >= drop_from));
      check("wr_buf_full", buf_full, (i >= drop_from));
      cyc();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (valid) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_valid: VALID still low after %0d cycles", limit);
  endtask

  // Acks the pending frame, then checks the stream window and the low gap that follows.
  task automatic ack_frame(input logic bf_exp, input logic ack_in_gap);
    @(negedge clk);
    check("pre_ack_state", rd_state, 2'd1);
    check("pre_ack_valid", valid, 1'b1);
    tx_ack = 1'b1;
    cyc();
    tx_ack = 1'b0;
    for (int k = 0; k < FW; k++) begin
      @(negedge clk);
      check("send_buf_full", buf_full, bf_exp);
      cyc();
    end
    for (int g = 0; g <= GAP; g++) begin
      if (ack_in_gap && g == 0) tx_ack = 1'b1;
      @(negedge clk);
      check("gap_valid", valid, 1'b0);
      check("gap_state", rd_state, (g < GAP) ? 2'd3 : 2'd0);
      check("gap_buf_full", buf_full, 1'b0);
      cyc();
      tx_ack = 1'b0;
    end
    model_rsel = ~model_rsel;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; tx_ack = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_dout", dout, 16'h0);
    check("rst_buf_full", buf_full, 1'b0);
    check("rst_ovfl", ovfl, 1'b0);
    check("rst_state", rd_state, 2'd0);
    cyc();

    // Basic frame: IDLE one cycle after the last write, VALID the cycle after.
    write_words(1, 4, 99);
    @(negedge clk);
    check("t1_idle_valid", valid, 1'b0);
    check("t1_idle_state", rd_state, 2'd0);
    cyc();
    @(negedge clk);
    check("t1_rise_valid", valid, 1'b1);
    check("t1_rise_state", rd_state, 2'd1);
    check("t1_prefetch", dout, 16'd1);
    ack_frame(1'b0, 1'b0);
    @(negedge clk);
    check("t1_stay_idle", valid, 1'b0);
    cyc();

    // Back-to-back: second frame pending, exactly GAP+1 low cycles between them.
    write_words(1, 8, 99);
    @(negedge clk);
    check("t2_both_full", buf_full, 1'b1);
    cyc();
    ack_frame(1'b1, 1'b0);
    ack_frame(1'b0, 1'b0);

    // Overflow: writes 9 and 10 are dropped.
    write_words(1, 10, 8);
    @(negedge clk);
    check("t3_full_after", buf_full, 1'b1);
    check("t3_ovfl_idle", ovfl, 1'b0);
    cyc();
    ack_frame(1'b1, 1'b0);
    ack_frame(1'b0, 1'b0);

    // ACK timing: word 0 held while un-acked; an ack during GAP is ignored.
    write_words(16'h40, 4, 99);
    wait_valid(10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_hold_dout", dout, 16'h40);
      check("t4_hold_state", rd_state, 2'd1);
      cyc();
    end
    ack_frame(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_ignored_ack", rd_state, 2'd0);
      cyc();
    end

    // Reset during word 2 of the stream with the other buffer also full.
    write_words(16'h50, 8, 99);
    wait_valid(10);
    tx_ack = 1'b1;
    cyc();
    tx_ack = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid", valid, 1'b0);
    check("t5_buf_full", buf_full, 1'b0);
    check("t5_state", rd_state, 2'd0);
    check("t5_dout", dout, 16'h0);
    check("t5_discard", exp_q.size(), 5);
    exp_q.delete();
    model_rsel = 1'b0;
    cyc();
    write_words(16'h60, 4, 99);
    wait_valid(10);
    ack_frame(1'b0, 1'b0);

    // SEU: corrupt one copy of state and of rsel mid-stream.
    write_words(16'h70, 4, 99);
    wait_valid(10);
    tx_ack = 1'b1;
    cyc();
    tx_ack = 1'b0;
    force dut.state_1 = 2'd0;
    if (model_rsel) force dut.rsel_1 = 1'b0;
    else            force dut.rsel_1 = 1'b1;
    cyc();
    cyc();
    release dut.state_1;
    release dut.rsel_1;
    cyc();
    cyc();
    @(negedge clk);
    check("t6_gap_state", rd_state, 2'd3);
    check("t6_gap_valid", valid, 1'b0);
    model_rsel = ~model_rsel;
    repeat (3) cyc();
    write_words(16'h80, 4, 99);
    wait_valid(10);
    ack_frame(1'b0, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
